pwm_capture: RTL and testbench

//  Measures a PWM waveform: period and high time, in clk cycles, rising edge to rising edge.

---
 rtl/pwm_capture.sv | 132 +++++++++++++
 tb/tb_pwm_capture.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// PWM period/high-time capture, rising edge to rising edge, with a one-entry valid/ready result register.
// Define PWM_CAPTURE_SYNC_EN to insert a 2-flop input synchroniser for asynchronous pwm_in sources.
module pwm_capture #(
    parameter int          CNT_W   = 32,
    parameter int unsigned TIMEOUT = 32'd1 << 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    input  logic             meas_ready,
    input  logic             clr_overrun,
    output logic             meas_valid,
    output logic [CNT_W-1:0] meas_period,
    output logic [CNT_W-1:0] meas_high,
    output logic             overrun,
    output logic             timeout,
    output logic             idle_level,
    output logic [1:0]       state_dbg    // 0 = IDLE, 1 = HIGH, 2 = LOW
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

    state_t           state;
    logic             s;
    logic             prev;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] high_cnt;
    logic             rise;
    logic             fall;
    logic             publish;
    logic             tmo;

`ifdef PWM_CAPTURE_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= pwm_in;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = pwm_in;
`endif

    assign rise      = s & ~prev;
    assign fall      = ~s & prev;
    assign publish   = (state == LOW) & rise;
    // A rise on the TIMEOUT-th cycle still closes a valid period, so it beats the timeout.
    assign tmo       = (state != IDLE) & ~rise & (period_cnt == TIMEOUT_C);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prev       <= 1'b0;
            period_cnt <= '0;
            high_cnt   <= '0;
            timeout    <= 1'b0;
            idle_level <= 1'b0;
        end else begin
            prev    <= s;
            timeout <= 1'b0;
            if (tmo) begin
                timeout    <= 1'b1;
                idle_level <= s;
                state      <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state      <= HIGH;
                            period_cnt <= ONE_C;
                            high_cnt   <= ONE_C;
                        end
                    end
                    HIGH: begin
                        period_cnt <= period_cnt + ONE_C;
                        if (fall) state    <= LOW;
                        else      high_cnt <= high_cnt + ONE_C;
                    end
                    LOW: begin
                        if (rise) begin
                            state      <= HIGH;
                            period_cnt <= ONE_C;
                            high_cnt   <= ONE_C;
                        end else begin
                            period_cnt <= period_cnt + ONE_C;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Result register handshake: a transfer happens when meas_valid & meas_ready at a clock
    // edge. Data holds while valid & ~ready; a new publish always wins over the slot, and
    // replacing an unaccepted result raises the sticky overrun flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            meas_valid  <= 1'b0;
            meas_period <= '0;
            meas_high   <= '0;
            overrun     <= 1'b0;
        end else begin
            if (publish) begin
                meas_valid  <= 1'b1;
                meas_period <= period_cnt;
                meas_high   <= high_cnt;
            end else if (meas_valid && meas_ready) begin
                meas_valid <= 1'b0;
            end
            if (publish && meas_valid && !meas_ready) overrun <= 1'b1;
            else if (clr_overrun)                     overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed scenarios plus random PWM trains, checked every cycle
// against a sample-history reference model (rise indices and high-sample counts).
module tb_pwm_capture;

    localparam int unsigned TMO = 64;
`ifdef PWM_CAPTURE_SYNC_EN
    localparam int DLY = 2;
`else
    localparam int DLY = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic        meas_ready = 1'b0;
    logic        clr_overrun = 1'b0;
    logic        meas_valid;
    logic [31:0] meas_period;
    logic [31:0] meas_high;
    logic        overrun;
    logic        timeout;
    logic        idle_level;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;
    int tmo_seen = 0;

    // reference model state
    int unsigned k = 0;
    int unsigned m_t0 = 0;
    int unsigned m_ones = 0;
    bit m_in_seg = 0, m_prev = 0, m_d1 = 0, m_d2 = 0;
    bit e_valid = 0, e_ovr = 0, e_tmo = 0, e_idle = 0;
    int unsigned e_period = 0, e_high = 0, e_state = 0;

    pwm_capture #(.CNT_W(32), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .pwm_in      (pwm_in),
        .meas_ready  (meas_ready),
        .clr_overrun (clr_overrun),
        .meas_valid  (meas_valid),
        .meas_period (meas_period),
        .meas_high   (meas_high),
        .overrun     (overrun),
        .timeout     (timeout),
        .idle_level  (idle_level),
        .state_dbg   (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        assert (act === exp) else begin
            errors++;
            $error("FAIL %s at edge %0d: got %0d expected %0d", tag, k, act, exp);
        end
    endtask

    // One clock edge of the model: period = distance between consecutive rises,
    // high = number of 1 samples from the earlier rise up to the later one.
    task automatic model_edge(input bit p, input bit r, input bit c, input bit rs);
        bit s, rise, pub, tmo_ev;
        int unsigned elapsed, pub_p, pub_h;
        k++;
        if (rs) begin
            m_in_seg = 0; m_prev = 0; m_d1 = 0; m_d2 = 0;
            e_valid = 0; e_ovr = 0; e_tmo = 0; e_idle = 0;
            e_period = 0; e_high = 0; e_state = 0;
            return;
        end
        if (DLY > 0) begin
            s = m_d2; m_d2 = m_d1; m_d1 = p;
        end else begin
            s = p;
        end
        rise = s && !m_prev;
        m_prev = s;
        pub = 0; tmo_ev = 0; pub_p = 0; pub_h = 0;
        if (m_in_seg) begin
            elapsed = k - m_t0;
            if (rise) begin
                pub = 1; pub_p = elapsed; pub_h = m_ones;
            end else if (elapsed == TMO) begin
                tmo_ev = 1;
            end else begin
                m_ones += int'(s);
            end
        end
        if (rise) begin
            m_in_seg = 1; m_t0 = k; m_ones = 1;
        end
        e_tmo = tmo_ev;
        if (tmo_ev) begin
            m_in_seg = 0; e_idle = s;
        end
        if (pub) begin
            if (e_valid && !r) e_ovr = 1;
            else if (c)        e_ovr = 0;
            e_valid = 1; e_period = pub_p; e_high = pub_h;
        end else begin
            if (e_valid && r) e_valid = 0;
            if (c) e_ovr = 0;
        end
        e_state = !m_in_seg ? 0 : (s ? 1 : 2);
    endtask

    task automatic tick(input bit p, input bit r, input bit c, input bit rs);
        pwm_in = p; meas_ready = r; clr_overrun = c; rst = rs;
        @(posedge clk);
        model_edge(p, r, c, rs);
        #1;
        chk("meas_valid", 32'(meas_valid), 32'(e_valid));
        chk("meas_period", meas_period, e_period);
        chk("meas_high", meas_high, e_high);
        chk("overrun", 32'(overrun), 32'(e_ovr));
        chk("timeout", 32'(timeout), 32'(e_tmo));
        chk("idle_level", 32'(idle_level), 32'(e_idle));
        chk("state", 32'(state_dbg), e_state);
        if (timeout === 1'b1) tmo_seen++;
    endtask

    // rmode/cmode: 0 = hold low, 1 = hold high, 2 = random
    task automatic pulse(input int h, input int l, input int rmode, input int cmode);
        for (int i = 0; i < h + l; i++) begin
            bit r, c;
            r = (rmode == 2) ? bit'($urandom_range(0, 1)) : bit'(rmode);
            c = (cmode == 2) ? ($urandom_range(0, 7) == 0) : bit'(cmode);
            tick(i < h, r, c, 1'b0);
        end
    endtask

    // Drive the closing rise and hold high until the synchronised rise reaches the detector.
    task automatic close_rise(input bit rfill, input bit rfinal);
        for (int i = 0; i <= DLY; i++) tick(1'b1, (i == DLY) ? rfinal : rfill, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        do_reset();
        chk("reset_valid", 32'(meas_valid), 32'd0);
        chk("reset_state", 32'(state_dbg), 32'd0);

        // steady 10/3 train with an always-ready consumer
        repeat (5) pulse(3, 7, 1, 0);
        close_rise(1'b1, 1'b1);
        chk("t1_period", meas_period, 32'd10);
        chk("t1_high", meas_high, 32'd3);
        chk("t1_valid", 32'(meas_valid), 32'd1);

        // two publishes with the consumer stalled, then clear overrun
        do_reset();
        pulse(2, 6, 0, 0);
        pulse(5, 3, 0, 0);
        close_rise(1'b0, 1'b0);
        chk("t2_period", meas_period, 32'd8);
        chk("t2_high", meas_high, 32'd5);
        chk("t2_overrun", 32'(overrun), 32'd1);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t2_clr", 32'(overrun), 32'd0);

        // accept of the first result coincides with the second publish
        do_reset();
        pulse(2, 6, 0, 0);
        pulse(5, 3, 0, 0);
        close_rise(1'b0, 1'b1);
        chk("t3_valid", 32'(meas_valid), 32'd1);
        chk("t3_high", meas_high, 32'd5);
        chk("t3_overrun", 32'(overrun), 32'd0);

        // input stuck high after one rise: exactly one timeout
        do_reset();
        tmo_seen = 0;
        repeat (3) tick(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (90) tick(1'b1, 1'b1, 1'b0, 1'b0);
        chk("t4_pulses", 32'(tmo_seen), 32'd1);
        chk("t4_idle_level", 32'(idle_level), 32'd1);
        chk("t4_state", 32'(state_dbg), 32'd0);
        chk("t4_valid", 32'(meas_valid), 32'd0);
        repeat (5) tick(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) pulse(5, 15, 1, 0);
        close_rise(1'b1, 1'b1);
        chk("t4_period", meas_period, 32'd20);

        // reset in the middle of a high phase with a pending result
        do_reset();
        repeat (2) pulse(3, 5, 0, 0);
        close_rise(1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t5_valid", 32'(meas_valid), 32'd0);
        chk("t5_period", meas_period, 32'd0);
        chk("t5_overrun", 32'(overrun), 32'd0);
        tick(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) pulse(4, 5, 1, 0);

        // shortest legal period
        do_reset();
        repeat (10) pulse(1, 1, 1, 0);
        close_rise(1'b1, 1'b1);
        chk("t6_period", meas_period, 32'd2);
        chk("t6_high", meas_high, 32'd1);

        // random trains, random consumer, occasional flat stretches long enough to time out
        do_reset();
        for (int n = 0; n < 80; n++) begin
            int h, l;
            h = int'($urandom_range(1, 12));
            l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(60, 90)) : int'($urandom_range(1, 12));
            pulse(h, l, 2, 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
